mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between two pipeline requesters: instruction fetch (IF, read-only) and the MEM stage (read/write).
- Sequences each access through a fixed-latency memory with an issue/wait/response state machine.
- Drives per-port stall outputs, which the pipeline ORs into its PC/IF2ID enables, so either stage freezes until its access completes.
- MEM has priority, bounded by a streak limit so fetch cannot starve.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter (instruction fetch + MEM stage) in front of one single-ported,
// fixed-latency memory; MEM has priority, bounded by a streak limit so fetch cannot starve.
module mem_port_arbiter #(
  parameter int n      = 16,
  parameter int AW     = 8,
  parameter int LAT    = 2,
  parameter int STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [n-1:0]  if_rdata,
  output logic          if_stall,
  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [n-1:0]  mem_wdata,
  output logic          mem_ack,
  output logic [n-1:0]  mem_rdata,
  output logic          mem_stall,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [n-1:0]  ram_wdata,
  input  logic [n-1:0]  ram_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int CW = $clog2(LAT + 1);
  localparam int SW = $clog2(STREAK + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(LAT);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   streak_q, streak_d;
  logic            owner_q, owner_d;
  logic            cmd_we_q, cmd_we_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [n-1:0]    cmd_wdata_q, cmd_wdata_d;
  logic [n-1:0]    if_rdata_q, if_rdata_d;
  logic [n-1:0]    mem_rdata_q, mem_rdata_d;
  logic            ram_en_q, ram_en_d;
  logic            ram_we_q, ram_we_d;
  logic            if_ack_q, if_ack_d;
  logic            mem_ack_q, mem_ack_d;
  logic            any_req;
  logic            grant_mem;

  assign any_req = if_req | mem_req;
  // Fetch only overrides MEM once MEM has won STREAK grants in a row while fetch waited.
  assign grant_mem = mem_req & ~(if_req & (streak_q == STREAK_MAX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == CNT_LAST) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          owner_d     = grant_mem;
          cmd_we_d    = grant_mem & mem_we;
          cmd_addr_d  = grant_mem ? mem_addr : if_addr;
          cmd_wdata_d = grant_mem ? mem_wdata : '0;
          if (grant_mem && if_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end
      end
      ISSUE: cnt_d = CW'(1);
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          // Writes leave both read-data registers untouched.
          if (!cmd_we_q) begin
            if (owner_q) mem_rdata_d = ram_rdata;
            else         if_rdata_d  = ram_rdata;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free flop outputs.
  always_comb begin
    ram_en_d  = (state_d == ISSUE);
    ram_we_d  = ram_en_d & cmd_we_d;
    if_ack_d  = (state_d == RESP) & ~owner_d;
    mem_ack_d = (state_d == RESP) & owner_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      streak_q    <= '0;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = cmd_addr_q;
  assign ram_wdata = cmd_wdata_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != IDLE);
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle table for reset/arbitration/timing,
// plus hand sequences for streak fairness, writes, and reset during an access (LAT=3).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance, LAT = 2
  logic        rst, if_req, mem_req, mem_we;
  logic [7:0]  if_addr, mem_addr;
  logic [15:0] mem_wdata;
  logic        if_ack, if_stall, mem_ack, mem_stall, ram_en, ram_we, busy, owner;
  logic [15:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic [7:0]  ram_addr;

  // Second instance, LAT = 3
  logic        rst3, if_req3, mem_req3, mem_we3;
  logic [7:0]  if_addr3, mem_addr3;
  logic [15:0] mem_wdata3;
  logic        if_ack3, if_stall3, mem_ack3, mem_stall3, ram_en3, ram_we3, busy3, owner3;
  logic [15:0] if_rdata3, mem_rdata3, ram_wdata3, ram_rdata3;
  logic [7:0]  ram_addr3;

  mem_port_arbiter #(.n(16), .AW(8), .LAT(2), .STREAK(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
  );

  mem_port_arbiter #(.n(16), .AW(8), .LAT(3), .STREAK(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3), .if_stall(if_stall3),
    .mem_req(mem_req3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_ack(mem_ack3), .mem_rdata(mem_rdata3), .mem_stall(mem_stall3),
    .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3), .ram_wdata(ram_wdata3),
    .ram_rdata(ram_rdata3), .busy(busy3), .owner(owner3)
  );

  // Shared memory model; read data appears exactly LAT cycles after the ram_en cycle.
  logic [15:0] mem [256];
  logic [15:0] pipe_a [1:2];
  logic [15:0] pipe_b [1:3];
  always @(posedge clk) begin
    if (rst) begin
      mem[8'h05] <= 16'hABCD;
      mem[8'h20] <= 16'h5A5A;
      mem[8'h10] <= 16'h0000;
    end else if (ram_en && ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    pipe_a[1] <= ram_en ? mem[ram_addr] : 16'hDEAD;
    pipe_a[2] <= pipe_a[1];
    pipe_b[1] <= ram_en3 ? mem[ram_addr3] : 16'hDEAD;
    pipe_b[2] <= pipe_b[1];
    pipe_b[3] <= pipe_b[2];
  end
  assign ram_rdata  = pipe_a[2];
  assign ram_rdata3 = pipe_b[3];

  int total  = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One table row = one clock cycle; flags = {ram_en, ram_we, if_ack, mem_ack, if_stall, mem_stall, owner, busy}
  typedef struct {
    logic       rst;
    logic       if_req;
    logic       mem_req;
    logic [7:0] exp_flags;
    logic [7:0] exp_addr;
    string      name;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic r, input logic ir, input logic mr,
                              input logic [7:0] fl, input logic [7:0] ad);
    vec_t v;
    v.name = nm; v.rst = r; v.if_req = ir; v.mem_req = mr; v.exp_flags = fl; v.exp_addr = ad;
    return v;
  endfunction

  vec_t tv [13];

  task automatic wait_ack3(input string name, output int lat);
    lat = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_ack3) begin
        lat = c;
        break;
      end
    end
    if (lat < 0) $display("FAIL %s: no if_ack within 20 cycles", name);
  endtask

  initial begin
    int          g;
    int          lat;
    int          bad;
    logic [5:0]  order;

    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    if_addr = 8'h05; mem_addr = 8'h20; mem_wdata = 16'h0000;
    rst3 = 1'b1; if_req3 = 1'b0; mem_req3 = 1'b0; mem_we3 = 1'b0;
    if_addr3 = 8'h00; mem_addr3 = 8'h00; mem_wdata3 = 16'h0000;

    tv[0]  = mk("rst_hold0",   1'b1, 1'b1, 1'b1, 8'b0000_1100, 8'h00);
    tv[1]  = mk("rst_hold1",   1'b1, 1'b1, 1'b1, 8'b0000_1100, 8'h00);
    tv[2]  = mk("both_idle",   1'b0, 1'b1, 1'b1, 8'b0000_1100, 8'h00);
    tv[3]  = mk("mem_issue",   1'b0, 1'b1, 1'b1, 8'b1000_1111, 8'h20);
    tv[4]  = mk("mem_wait1",   1'b0, 1'b1, 1'b1, 8'b0000_1111, 8'h00);
    tv[5]  = mk("mem_wait2",   1'b0, 1'b1, 1'b1, 8'b0000_1111, 8'h00);
    tv[6]  = mk("mem_resp",    1'b0, 1'b1, 1'b1, 8'b0001_1011, 8'h00);
    tv[7]  = mk("if_idle",     1'b0, 1'b1, 1'b0, 8'b0000_1010, 8'h00);
    tv[8]  = mk("if_issue",    1'b0, 1'b1, 1'b0, 8'b1000_1001, 8'h05);
    tv[9]  = mk("if_wait1",    1'b0, 1'b1, 1'b0, 8'b0000_1001, 8'h00);
    tv[10] = mk("if_wait2",    1'b0, 1'b1, 1'b0, 8'b0000_1001, 8'h00);
    tv[11] = mk("if_resp",     1'b0, 1'b1, 1'b0, 8'b0010_0001, 8'h00);
    tv[12] = mk("quiet_idle",  1'b0, 1'b0, 1'b0, 8'b0000_0000, 8'h00);

    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      rst = tv[i].rst; if_req = tv[i].if_req; mem_req = tv[i].mem_req;
      @(negedge clk);
      chk(tv[i].name, {56'd0, ram_en, ram_we, if_ack, mem_ack, if_stall, mem_stall, owner, busy},
          {56'd0, tv[i].exp_flags});
      if (tv[i].exp_flags[7]) chk({tv[i].name, "_addr"}, {56'd0, ram_addr}, {56'd0, tv[i].exp_addr});
      if (i == 1) chk("rst_rdata", {32'd0, if_rdata, mem_rdata}, 64'd0);
    end
    chk("table_rdata", {32'd0, if_rdata, mem_rdata}, {32'd0, 16'hABCD, 16'h5A5A});

    // Both ports requesting continuously: expect M,M,M,M,I,M
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 8'h05; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h20;
    g = 0; order = '0;
    for (int c = 0; c < 60 && g < 6; c++) begin
      @(negedge clk);
      if (ram_en) begin
        order = {order[4:0], owner};
        g++;
      end
    end
    chk("streak_grants", 64'(g), 64'd6);
    chk("streak_order", {58'd0, order}, {58'd0, 6'b111101});
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("streak_idle", {63'd0, busy}, 64'd0);
    chk("streak_rdata", {32'd0, if_rdata, mem_rdata}, {32'd0, 16'hABCD, 16'h5A5A});

    // MEM write, with requester inputs changed right after the grant, then read back
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 16'h1234;
    @(negedge clk);
    chk("wr_stall", {63'd0, mem_stall}, 64'd1);
    @(posedge clk); #1;
    mem_addr = 8'h11; mem_wdata = 16'hFFFF; mem_we = 1'b0;
    @(negedge clk);
    chk("wr_cmd", {38'd0, ram_en, ram_we, ram_addr, ram_wdata}, {38'd0, 1'b1, 1'b1, 8'h10, 16'h1234});
    repeat (3) @(negedge clk);
    chk("wr_ack_rdata", {47'd0, mem_ack, mem_rdata}, {47'd0, 1'b1, 16'h5A5A});
    @(posedge clk); #1;
    mem_req = 1'b0;
    @(posedge clk); #1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 8'h10;
    repeat (5) @(negedge clk);
    chk("rd_back", {31'd0, mem_ack, mem_rdata, if_rdata}, {31'd0, 1'b1, 16'h1234, 16'hABCD});
    @(posedge clk); #1;
    mem_req = 1'b0;

    // LAT = 3 instance: normal read, reset during WAIT, then a fresh read
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 8'h05;
    wait_ack3("l3_first", lat);
    chk("l3_ack_lat", 64'(lat), 64'd5);
    chk("l3_rdata", {48'd0, if_rdata3}, {48'd0, 16'hABCD});
    @(posedge clk); #1;
    if_req3 = 1'b0;
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 8'h20;
    repeat (3) @(posedge clk);
    #1;
    rst3 = 1'b1; if_req3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b0;
    bad = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (if_ack3 || ram_en3 || busy3) bad++;
    end
    chk("l3_rst_abort", 64'(bad), 64'd0);
    chk("l3_rst_rdata", {48'd0, if_rdata3}, 64'd0);
    @(posedge clk); #1;
    if_req3 = 1'b1; if_addr3 = 8'h20;
    wait_ack3("l3_fresh", lat);
    chk("l3_fresh_lat", 64'(lat), 64'd5);
    chk("l3_fresh_rdata", {48'd0, if_rdata3}, {48'd0, 16'h5A5A});
    @(posedge clk); #1;
    if_req3 = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
